keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Parametrised matrix-keypad front end: drives active-low column strobes, samples active-low row returns, debounces whole scan frames, and maps each physical key to its logical code through a configurable table.
- Emits one valid/ready event per new key press and a level bitmap of held keys, both in logical-code order.
- Sits between the board keypad pins and the input/command logic.
- Default mapping is the team's 4x4 layout: digits 0-9 -> codes 0-9, A-D -> 10-13, # -> 14, * -> 15.

Parameters:
ROWS, 4, number of row inputs
COLS, 4, number of column strobes
CODE_W, 4, logical code width; must be >= clog2(ROWS*COLS)
SCAN_DIV, 100000, clock cycles each column is driven; frame = COLS*SCAN_DIV cycles
DEB_FRAMES, 4, consecutive identical frames required before the debounced state updates; must be >= 1
MAP, 64'hDCBA_E963_0852_F741, ROWS*COLS*CODE_W-bit table; entry i at bits [CODE_W*i +: CODE_W] is the logical code of physical key i; must be a permutation of 0..ROWS*COLS-1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
row_n  in  ROWS  row returns, active-low, asynchronous to clk (2-flop synchronised inside)
col_n  out  COLS  column strobes, exactly one bit low at any time
key_valid  out  1  press event available
key_ready  in  1  consumer accepts event when high with key_valid
key_code  out  CODE_W  logical code of the event; stable while key_valid && !key_ready
key_state  out  ROWS*COLS  debounced held-key bitmap; bit MAP[i] set while physical key i is held
key_any  out  1  OR of key_state

Behaviour:
- Reset values: col_n = ~1 (column 0 driven); key_valid = 0; key_code = 0; key_state = 0; key_any = 0. Reset also clears scan counters, snapshot, debounce counter and pending mask.
- Physical index: i = c*ROWS + r, where c is the driven column and r is the row sampled low.
- Scan:
  - A dwell counter counts 0..SCAN_DIV-1.
  - On the terminal count, the synchronised ~row_n is written into the snapshot bits for the current column.
  - The column index then advances, wrapping from COLS-1 to 0, and col_n moves to the next column on the same edge.
- Frame end is the terminal count of column COLS-1:
  - If the completed snapshot equals the previous frame's snapshot, the stable count increments (saturating). Otherwise it resets to 1.
  - When the stable count reaches DEB_FRAMES, the stable matrix is loaded from the snapshot on that edge.
  - With DEB_FRAMES = 1, every frame loads.
- Edge detect:
  - On each stable-matrix load, bits that go 0->1 are ORed into a pending mask.
  - Releases never generate events.
  - A key already pending that is released and re-pressed is not duplicated.
- Event output:
  - When key_valid = 0 and pending != 0, on the next edge: select the lowest set physical index, set key_code = MAP entry, set key_valid = 1, and clear that pending bit.
  - Handshake: the transfer occurs on an edge with key_valid && key_ready.
  - After a transfer, the next pending event (if any) is presented on that same edge, giving back-to-back events one per cycle.
  - key_valid and key_code hold while not accepted. A pending press stays reportable even if the key is released before acceptance.
- key_state / key_any are registered, mapped from the stable matrix, and update one cycle after the stable load.
- Latency, press to key_valid: up to DEB_FRAMES+1 frames of scanning, plus 2 sync cycles, plus 2 cycles.
- Simultaneous presses within one frame: reported in ascending physical index. Ghosting is not resolved.
- rst mid-operation discards the pending and in-flight event: key_valid = 0 and col_n = ~1 on the next edge.

Test Plan:
- Reset check (SCAN_DIV=4, DEB_FRAMES=3 throughout): assert rst -> col_n=4'b1110, key_valid=0, key_state=0. Release rst -> col_n steps 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
- Single press, default MAP: hold row_n[1] low only while col_n[0] is low (physical 1) -> key_valid within 4 frames + 4 cycles, key_code=4, key_state=16'h0010, key_any=1.
  - Keep key_ready=0 for 20 cycles -> key_valid/key_code stay stable.
  - Pulse key_ready -> exactly one event; no repeat while the key is held.
  - Release -> key_state=0 after 3 frames; no event.
- Bounce: toggle the physical-1 contact every 8 cycles for 10 frames -> no key_valid, key_state=0. Then hold steady -> exactly one event with code 4.
- Two keys pressed in the same frame, physical 3 (*) and 12 (A), with key_ready=1 -> key_code 15 then 10 on consecutive cycles; key_state=16'h8400.
- Backpressure: physical 7 and 8 pressed with key_ready=0 -> key_code=0 held. Release both before accepting, then raise ready -> events 0 then 3; key_state already 0.
- Reset mid-operation: rst while key_valid=1 and one further press is pending -> next cycle key_valid=0, col_n=1110; no event after rst falls until new presses.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix keypad scan, frame debounce, mapped press events and held-key bitmap
module keypad_scanner #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CODE_W = 4,
    parameter int SCAN_DIV = 100000,
    parameter int DEB_FRAMES = 4,
    parameter logic [ROWS*COLS*CODE_W-1:0] MAP = 64'hDCBA_E963_0852_F741
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      row_n,
    output logic [COLS-1:0]      col_n,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [CODE_W-1:0]    key_code,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 key_any
);
    localparam int N = ROWS * COLS;
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    localparam int SW = $clog2(DEB_FRAMES + 1);

    logic [ROWS-1:0]   meta_q, meta_d, sync_q, sync_d;
    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     col_q, col_d;
    logic [N-1:0]      snap_q, snap_d, prev_q, prev_d, stable_q, stable_d;
    logic [N-1:0]      pend_q, pend_d, state_q, state_d, lowest, rise;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              valid_q, valid_d, any_q, any_d, div_tc, frame_end, load, take;
    logic [CODE_W-1:0] code_q, code_d, code_sel;

    // Row synchroniser, column dwell/advance and per-column snapshot capture
    always_comb begin
        meta_d = ~row_n;
        sync_d = meta_q;
        div_tc = div_q == DW'(SCAN_DIV - 1);
        div_d = div_tc ? '0 : div_q + 1'b1;
        col_d = div_tc ? (col_q == CW'(COLS - 1) ? '0 : col_q + 1'b1) : col_q;
        frame_end = div_tc && col_q == CW'(COLS - 1);
        snap_d = snap_q;
        for (int c = 0; c < COLS; c++)
            if (div_tc && col_q == CW'(c)) snap_d[c*ROWS +: ROWS] = sync_q;
    end

    // Whole-frame debounce: count identical consecutive frames and load the stable matrix once enough agree
    always_comb begin
        prev_d = frame_end ? snap_d : prev_q;
        cnt_d = cnt_q;
        if (frame_end)
            cnt_d = snap_d != prev_q ? SW'(1) : (cnt_q == SW'(DEB_FRAMES) ? cnt_q : cnt_q + 1'b1);
        load = frame_end && cnt_d == SW'(DEB_FRAMES);
        stable_d = load ? snap_d : stable_q;
        rise = load ? snap_d & ~stable_q : '0;
    end

    // Press events: lowest pending physical index is presented whenever the output slot is free or just accepted
    always_comb begin
        lowest = pend_q & (~pend_q + 1'b1);
        code_sel = '0;
        for (int i = 0; i < N; i++)
            if (lowest[i]) code_sel = MAP[CODE_W*i +: CODE_W];
        take = (!valid_q || key_ready) && pend_q != '0;
        valid_d = take || (valid_q && !key_ready);
        code_d = take ? code_sel : code_q;
        pend_d = (pend_q | rise) & ~(take ? lowest : '0);
    end

    // Held-key bitmap reordered into logical-code positions
    always_comb begin
        state_d = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (MAP[CODE_W*i +: CODE_W] == CODE_W'(j)) state_d[j] = stable_q[i];
        any_d = |state_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            div_q <= '0;
            col_q <= '0;
            snap_q <= '0;
            prev_q <= '0;
            cnt_q <= '0;
            stable_q <= '0;
            pend_q <= '0;
            valid_q <= 1'b0;
            code_q <= '0;
            state_q <= '0;
            any_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            div_q <= div_d;
            col_q <= col_d;
            snap_q <= snap_d;
            prev_q <= prev_d;
            cnt_q <= cnt_d;
            stable_q <= stable_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
            code_q <= code_d;
            state_q <= state_d;
            any_q <= any_d;
        end
    end

    assign col_n = ~(COLS'(1) << col_q);
    assign key_valid = valid_q;
    assign key_code = code_q;
    assign key_state = state_q;
    assign key_any = any_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized frame-level keypad stimulus with scoreboarded press events
module tb_keypad_scanner;
    localparam logic [63:0] MAP_TB = 64'hDCBA_E963_0852_F741;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n, col_n, key_code;
    logic        key_valid, key_any;
    logic        key_ready = 1'b0;
    logic [15:0] key_state;
    logic [15:0] press = '0;

    int tests = 0, fails = 0;
    int exp_q[$];
    logic [15:0] m_prev = '0, m_stable = '0, m_pend = '0;
    int m_cnt = 0;
    int ready_mode = 0, starve = 0;
    int cyc = 0, last_x = 0, prev_x = 0;
    logic hold = 1'b0;
    logic [3:0] hcode = '0;
    int p_idx;

    always #5 clk = ~clk;

    keypad_scanner #(.ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4), .DEB_FRAMES(DEB), .MAP(MAP_TB)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .key_valid(key_valid),
        .key_ready(key_ready), .key_code(key_code), .key_state(key_state), .key_any(key_any)
    );

    // Passive keypad: a held key pulls its row low while its column is strobed
    always_comb begin
        row_n = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && press[c*4+r]) row_n[r] = 1'b0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] code_of(int i);
        return 4'((MAP_TB >> (4*i)) & 64'hF);
    endfunction

    function automatic logic [15:0] state_of(logic [15:0] s);
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[code_of(i)] = s[i];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: one call per scanned frame with the key set held for that whole frame
    task automatic model_frame();
        logic [15:0] r;
        m_cnt = (press == m_prev) ? (m_cnt < DEB ? m_cnt + 1 : DEB) : 1;
        m_prev = press;
        if (m_cnt == DEB) begin
            r = press & ~m_stable;
            m_stable = press;
            for (int i = 0; i < 16; i++)
                if (r[i] && !m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    exp_q.push_back(i);
                end
        end
    endtask

    task automatic run_frame();
        logic [3:0] ec;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            ec = ~(4'b0001 << (j / 4));
            chk("col_n", col_n, ec);
            if (j == 1) begin
                chk("key_state", key_state, state_of(m_stable));
                chk("key_any", key_any, |m_stable);
            end
            @(posedge clk);
        end
        #1;
        model_frame();
    endtask

    task automatic frames(int n, logic [15:0] p);
        press = p;
        repeat (n) run_frame();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        press = '0;
        exp_q.delete();
        m_prev = '0;
        m_stable = '0;
        m_pend = '0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        chk("rst_valid", key_valid, 0);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_state", key_state, 0);
        chk("rst_any", key_any, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b0;
    endtask

    // Consumer: fixed low, fixed high, or random ready with a bound on starvation
    initial forever begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) key_ready = 1'b0;
        else if (ready_mode == 1) key_ready = 1'b1;
        else key_ready = ($urandom_range(0, 3) != 0) || starve >= 4;
        starve = (key_valid && !key_ready) ? starve + 1 : 0;
    end

    // Monitor: pops the scoreboard on each transfer and checks that unaccepted events stay put
    initial forever begin
        @(negedge clk);
        if (rst) hold = 1'b0;
        else begin
            if (hold) chk("hold_stable", {key_valid, key_code}, {1'b1, hcode});
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got code %0d expected none at cycle %0d", key_code, cyc);
                end else begin
                    p_idx = exp_q.pop_front();
                    chk("event_code", key_code, code_of(p_idx));
                    m_pend[p_idx] = 1'b0;
                end
                prev_x = last_x;
                last_x = cyc;
            end
            hold = key_valid && !key_ready;
            hcode = key_code;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] p;
        repeat (2) @(posedge clk);
        do_reset();
        frames(2, '0);
        ready_mode = 0;
        frames(4, 16'h0002);
        chk("single_valid", key_valid, 1);
        chk("single_code", key_code, 4);
        chk("single_state", key_state, 16'h0010);
        chk("single_any", key_any, 1);
        frames(2, 16'h0002);
        chk("single_held", {key_valid, key_code}, {1'b1, 4'd4});
        ready_mode = 1;
        frames(1, 16'h0002);
        ready_mode = 2;
        frames(2, 16'h0002);
        chk("no_repeat", key_valid, 0);
        chk("single_drained", exp_q.size(), 0);
        frames(4, '0);
        chk("release_state", key_state, 0);
        for (int k = 0; k < 10; k++) frames(1, (k % 2 == 0) ? 16'h0002 : 16'h0000);
        chk("bounce_valid", key_valid, 0);
        chk("bounce_state", key_state, 0);
        frames(4, 16'h0002);
        chk("bounce_drained", exp_q.size(), 0);
        frames(4, '0);
        ready_mode = 1;
        frames(4, 16'h1008);
        chk("two_state", key_state, 16'h8400);
        chk("two_back_to_back", last_x - prev_x, 1);
        chk("two_drained", exp_q.size(), 0);
        frames(4, '0);
        ready_mode = 0;
        frames(4, 16'h0180);
        chk("bp_valid", key_valid, 1);
        chk("bp_code", key_code, 0);
        frames(4, '0);
        chk("bp_state", key_state, 0);
        chk("bp_still", {key_valid, key_code}, {1'b1, 4'd0});
        ready_mode = 1;
        frames(1, '0);
        chk("bp_drained", exp_q.size(), 0);
        ready_mode = 0;
        frames(4, 16'h0024);
        chk("mid_valid", key_valid, 1);
        chk("mid_code", key_code, 7);
        do_reset();
        ready_mode = 2;
        frames(4, '0);
        chk("post_rst_quiet", key_valid, 0);
        repeat (30) begin
            p = '0;
            repeat ($urandom_range(0, 3)) p[$urandom_range(0, 15)] = 1'b1;
            frames($urandom_range(1, 4), p);
        end
        frames(4, '0);
        ready_mode = 1;
        frames(1, '0);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
